// File: rtl/counter_snapshot_streamer_if.sv
// Narrow valid/ready word stream carrying serialized counter snapshots.
interface counter_snapshot_streamer_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (output out_data, output out_valid, output out_last, input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/counter_snapshot_streamer.sv
// Snapshots a wide counter into a small FIFO on capture pulses and streams each
// snapshot out LSW-first as NW words over a valid/ready interface.
module counter_snapshot_streamer #(
  parameter int COUNT_WIDTH = 129,
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   capture,
  input  logic                   clear_overflow,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  counter_snapshot_streamer_if.master stream
);
  localparam int NW  = (COUNT_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int SHW = NW * WORD_WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  logic [COUNT_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]            wp, rp;
  logic                   full, empty, pop, push, drop;
  logic [COUNT_WIDTH-1:0] rd_data;

  state_t         state, state_n;
  logic [SHW-1:0] shift, shift_n;
  logic [IW-1:0]  idx, idx_n;
  logic           valid, valid_n;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];
  assign push    = capture && (!full || pop);
  assign drop    = capture && !push;

  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    valid_n = valid;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = SHW'(rd_data);
          idx_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (!valid) begin
          valid_n = 1'b1;
        end else if (stream.out_ready) begin
          if (idx != LAST_IDX) begin
            shift_n = shift >> WORD_WIDTH;
            idx_n   = idx + 1'b1;
          end else if (!empty) begin
            // Chain straight into the next snapshot so the stream has no bubble.
            pop     = 1'b1;
            shift_n = SHW'(rd_data);
            idx_n   = '0;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
      valid <= valid_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= count_in;
  end

  // A clear coinciding with a drop still records that one drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign stream.out_data  = shift[WORD_WIDTH-1:0];
  assign stream.out_valid = valid;
  assign stream.out_last  = valid && (idx == LAST_IDX);
endmodule
